// File: rtl/comparator_pkg.sv
// Shared comparison opcodes and opcode helpers for the comparator pipeline.
package comparator_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 64;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_op_t;

  // 010 and 011 are the only unencoded values.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op[2] | ~op[1];
  endfunction

  // EQ/NE (and the illegal codes) fall back to signed ordering for min/max.
  function automatic logic op_is_unsigned(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/comparator_pipe_if.sv
// Valid/ready operand and result bundle for comparator_pipe.
// min_out/max_out exist only when COMPARATOR_MINMAX_EN is defined.
interface comparator_pipe_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic         result;
  logic         illegal_op;
`ifdef COMPARATOR_MINMAX_EN
  logic [N-1:0] min_out;
  logic [N-1:0] max_out;
`endif

  modport slave (
    input  in_valid, a, b, op, out_ready,
`ifdef COMPARATOR_MINMAX_EN
    output min_out, max_out,
`endif
    output in_ready, out_valid, result, illegal_op
  );

  modport master (
    output in_valid, a, b, op, out_ready,
`ifdef COMPARATOR_MINMAX_EN
    input  min_out, max_out,
`endif
    input  in_ready, out_valid, result, illegal_op
  );

endinterface

// File: rtl/adder_n.sv
// N-bit ripple adder with carry in/out; used as the pipeline's subtractor.
module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/comparator_pipe.sv
// Two-stage valid/ready comparator: S1 captures operands, a-b and carry; S2 captures the outcome.
// Build option COMPARATOR_MINMAX_EN adds registered min_out/max_out.
module comparator_pipe
  import comparator_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  comparator_pipe_if.slave  bus
);

  logic [N-1:0] diff;
  logic         carry;

  logic         s1_valid_q, s1_valid_d;
  logic [2:0]   op_q,       op_d;
  logic [N-1:0] diff_q,     diff_d;
  logic         carry_q,    carry_d;
  logic         a_msb_q,    a_msb_d;
  logic         b_msb_q,    b_msb_d;

  logic         s2_valid_q, s2_valid_d;
  logic         result_q,   result_d;
  logic         illegal_q,  illegal_d;

  logic         s1_load;
  logic         s2_load;
  logic         eq;
  logic         lt_s;
  logic         lt_u;
  logic         cmp_res;
  logic         cmp_ill;

`ifdef COMPARATOR_MINMAX_EN
  logic [N-1:0] a_q,   a_d;
  logic [N-1:0] b_q,   b_d;
  logic [N-1:0] min_q, min_d;
  logic [N-1:0] max_q, max_d;
  logic         sel_lt;
`endif

  // a - b computed as a + ~b + 1; carry-out set means no borrow.
  adder_n #(.N(N)) u_sub (
    .a_i   (bus.a),
    .b_i   (~bus.b),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(carry)
  );

  assign s2_load = !s2_valid_q || bus.out_ready;
  assign s1_load = !s1_valid_q || s2_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    diff_d     = diff_q;
    carry_d    = carry_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
`ifdef COMPARATOR_MINMAX_EN
    a_d        = a_q;
    b_d        = b_q;
`endif
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        op_d    = bus.op;
        diff_d  = diff;
        carry_d = carry;
        a_msb_d = bus.a[N-1];
        b_msb_d = bus.b[N-1];
`ifdef COMPARATOR_MINMAX_EN
        a_d     = bus.a;
        b_d     = bus.b;
`endif
      end
    end
  end

  // Differing signs decide signed order directly, so N-bit wrap of a-b cannot mislead.
  always_comb begin
    eq      = (diff_q == '0);
    lt_s    = (a_msb_q != b_msb_q) ? a_msb_q : diff_q[N-1];
    lt_u    = ~carry_q;
    cmp_ill = ~op_is_legal(op_q);
    cmp_res = 1'b0;
    case (op_q)
      CMP_EQ:  cmp_res = eq;
      CMP_NE:  cmp_res = ~eq;
      CMP_LT:  cmp_res = lt_s;
      CMP_GE:  cmp_res = ~lt_s;
      CMP_LTU: cmp_res = lt_u;
      CMP_GEU: cmp_res = ~lt_u;
      default: cmp_res = 1'b0;
    endcase
  end

`ifdef COMPARATOR_MINMAX_EN
  assign sel_lt = op_is_unsigned(op_q) ? lt_u : lt_s;
`endif

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    illegal_d  = illegal_q;
`ifdef COMPARATOR_MINMAX_EN
    min_d      = min_q;
    max_d      = max_q;
`endif
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d  = cmp_res;
        illegal_d = cmp_ill;
`ifdef COMPARATOR_MINMAX_EN
        min_d     = sel_lt ? a_q : b_q;
        max_d     = sel_lt ? b_q : a_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      op_q       <= 3'b000;
      diff_q     <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op_q       <= op_d;
      diff_q     <= diff_d;
      carry_q    <= carry_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef COMPARATOR_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign bus.min_out = min_q;
  assign bus.max_out = max_q;
`endif

  assign bus.in_ready   = s1_load;
  assign bus.out_valid  = s2_valid_q;
  assign bus.result     = result_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_comparator_pipe.sv
// Directed checks on a 32-bit instance and a randomized scoreboard run on an 8-bit instance.
module tb_comparator_pipe;

  typedef struct {
    logic        res;
    logic        ill;
    logic [63:0] mn;
    logic [63:0] mx;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        res;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  exp_t q8[$];
  exp_t q32[$];
  vec_t dir_v[14];
  vec_t st_v[3];
  logic [7:0] edges[4];

  comparator_pipe_if #(.N(32)) bus32 ();
  comparator_pipe_if #(.N(8))  bus8 ();

  comparator_pipe #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  comparator_pipe #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer comparisons on sign-extended / zero-extended values.
  function automatic exp_t ref_cmp(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic [2:0] op, input int n);
    exp_t        e;
    logic [63:0] mask, ua, ub;
    longint      sa, sb;
    logic        lt;
    mask = (64'd1 << n) - 64'd1;
    ua = a_in & mask;
    ub = b_in & mask;
    sa = ua[n-1] ? longint'(ua) - (longint'(1) << n) : longint'(ua);
    sb = ub[n-1] ? longint'(ub) - (longint'(1) << n) : longint'(ub);
    e.ill = 1'b0;
    case (op)
      3'd0:    e.res = (ua == ub);
      3'd1:    e.res = (ua != ub);
      3'd4:    e.res = (sa < sb);
      3'd5:    e.res = (sa >= sb);
      3'd6:    e.res = (ua < ub);
      3'd7:    e.res = (ua >= ub);
      default: begin e.res = 1'b0; e.ill = 1'b1; end
    endcase
    lt   = (op == 3'd6 || op == 3'd7) ? (ua < ub) : (sa < sb);
    e.mn = lt ? ua : ub;
    e.mx = lt ? ub : ua;
    return e;
  endfunction

  task automatic chk_out32(input string tag, input exp_t e);
    chk({tag, "_result"}, bus32.result, e.res);
    chk({tag, "_illegal"}, bus32.illegal_op, e.ill);
`ifdef COMPARATOR_MINMAX_EN
    chk({tag, "_min"}, bus32.min_out, e.mn);
    chk({tag, "_max"}, bus32.max_out, e.mx);
`endif
  endtask

  // Call at negedge+1 with the pipe empty apart from a result being consumed.
  task automatic send32(input vec_t v, input string tag);
    exp_t e;
    e = ref_cmp(v.a, v.b, v.op, 32);
    bus32.a = v.a; bus32.b = v.b; bus32.op = v.op;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, bus32.in_ready, 1'b1);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #1 chk({tag, "_lat1_valid"}, bus32.out_valid, 1'b0);
    @(negedge clk);
    #1 chk({tag, "_lat2_valid"}, bus32.out_valid, 1'b1);
    chk({tag, "_res_const"}, bus32.result, v.res);
    chk({tag, "_ill_const"}, bus32.illegal_op, v.ill);
    chk_out32(tag, e);
  endtask

  task automatic idle32(input int n);
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int   got, sent, cyc;
    exp_t e;

    edges = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    dir_v[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b0};
    dir_v[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 1'b0};
    dir_v[2]  = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b1, 1'b0};
    dir_v[3]  = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0, 1'b0};
    dir_v[4]  = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 1'b0, 1'b0};
    dir_v[5]  = '{32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 1'b1, 1'b0};
    dir_v[6]  = '{32'h0000_0005, 32'h0000_0005, 3'b010, 1'b0, 1'b1};
    dir_v[7]  = '{32'h0000_0005, 32'h0000_0005, 3'b011, 1'b0, 1'b1};
    dir_v[8]  = '{32'h0000_1234, 32'h0000_1234, 3'b000, 1'b1, 1'b0};
    dir_v[9]  = '{32'h0000_1234, 32'h0000_1234, 3'b001, 1'b0, 1'b0};
    dir_v[10] = '{32'h0000_1234, 32'h0000_1234, 3'b100, 1'b0, 1'b0};
    dir_v[11] = '{32'h0000_1234, 32'h0000_1234, 3'b101, 1'b1, 1'b0};
    dir_v[12] = '{32'h0000_1234, 32'h0000_1234, 3'b110, 1'b0, 1'b0};
    dir_v[13] = '{32'h0000_1234, 32'h0000_1234, 3'b111, 1'b1, 1'b0};
    st_v[0]   = '{32'h0000_0003, 32'h0000_0003, 3'b000, 1'b1, 1'b0};
    st_v[1]   = '{32'h0000_0009, 32'h0000_0009, 3'b001, 1'b0, 1'b0};
    st_v[2]   = '{32'h0000_0002, 32'h0000_0003, 3'b110, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    bus32.a = '0; bus32.b = '0; bus32.op = 3'b000;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus8.a = '0; bus8.b = '0; bus8.op = 3'b000;

    #2;
    chk("rst_out_valid", bus32.out_valid, 1'b0);
    chk("rst_result", bus32.result, 1'b0);
    chk("rst_illegal", bus32.illegal_op, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", bus32.in_ready, 1'b1);
    chk("post_rst_out_valid", bus32.out_valid, 1'b0);

    foreach (dir_v[i]) send32(dir_v[i], $sformatf("dir%0d", i));
`ifdef COMPARATOR_MINMAX_EN
    chk("minmax_const", 64'(dir_v[3].a), 64'h8000_0000);
`endif

    // Back-to-back with consumer stalled: two fill the pipe, the third waits.
    idle32(2);
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus32.a = st_v[i].a; bus32.b = st_v[i].b; bus32.op = st_v[i].op;
      bus32.in_valid = 1'b1;
      #1 chk($sformatf("b2b_in_ready%0d", i), bus32.in_ready, (i < 2) ? 1'b1 : 1'b0);
      if (i < 2) q32.push_back(ref_cmp(st_v[i].a, st_v[i].b, st_v[i].op, 32));
      @(negedge clk);
    end
    repeat (2) begin
      #1 chk("stall_in_ready", bus32.in_ready, 1'b0);
      chk("stall_out_valid", bus32.out_valid, 1'b1);
      chk_out32("stall_hold", q32[0]);
      @(negedge clk);
    end
    bus32.out_ready = 1'b1;
    #1 chk("release_in_ready", bus32.in_ready, 1'b1);
    q32.push_back(ref_cmp(st_v[2].a, st_v[2].b, st_v[2].op, 32));
    got = 0;
    for (int k = 0; k < 8 && got < 3; k++) begin
      if (bus32.out_valid) begin
        chk_out32($sformatf("b2b_out%0d", got), q32.pop_front());
        got++;
      end
      @(negedge clk);
      bus32.in_valid = 1'b0;
      #1;
    end
    chk("b2b_count", got, 3);

    // Reset with two items held in the pipe.
    idle32(2);
    bus32.out_ready = 1'b0;
    bus32.a = 32'd1; bus32.b = 32'd2; bus32.op = 3'b100; bus32.in_valid = 1'b1;
    @(negedge clk);
    bus32.a = 32'd7; bus32.b = 32'd7; bus32.op = 3'b000;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #1 chk("inflight_out_valid", bus32.out_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk("async_rst_out_valid", bus32.out_valid, 1'b0);
    chk("async_rst_result", bus32.result, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    #1 chk("rst_release_in_ready", bus32.in_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      #1 chk("no_stale_out", bus32.out_valid, 1'b0);
    end
    send32(dir_v[4], "after_rst");
    idle32(2);

    // Randomized N=8 run against the queue-based reference.
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus8.in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      bus8.a         = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
      bus8.b         = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
      bus8.op        = 3'($urandom_range(0, 7));
      bus8.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      chk("rnd_in_ready", bus8.in_ready, (q8.size() < 2) || bus8.out_ready);
      if (q8.size() != 1) chk("rnd_out_valid", bus8.out_valid, q8.size() == 2);
      if (bus8.out_valid && q8.size() > 0) begin
        chk("rnd_result", bus8.result, q8[0].res);
        chk("rnd_illegal", bus8.illegal_op, q8[0].ill);
`ifdef COMPARATOR_MINMAX_EN
        chk("rnd_min", bus8.min_out, q8[0].mn);
        chk("rnd_max", bus8.max_out, q8[0].mx);
`endif
        if (bus8.out_ready) begin
          void'(q8.pop_front());
          got++;
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        e = ref_cmp(64'(bus8.a), 64'(bus8.b), bus8.op, 8);
        q8.push_back(e);
        sent++;
      end
    end
    chk("rnd_consumed", got, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
